// File: rtl/rams_sdp_fifo_ctrl.sv
// FIFO controller around a simple dual-port RAM with a 1-cycle registered read port.
// A two-entry output buffer (head + skid) turns the RAM read latency into a FWFT stream.
module rams_sdp_fifo_ctrl #(
    parameter int D = 16,
    parameter int A = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [D-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [D-1:0] out_data,
    output logic [A:0]   count,
    output logic         ram_ena,
    output logic         ram_wea,
    output logic [A-1:0] ram_addra,
    output logic [D-1:0] ram_dia,
    output logic         ram_enb,
    output logic [A-1:0] ram_addrb,
    input  logic [D-1:0] ram_dob
);

    localparam logic [A:0] DEPTH_C = {1'b1, {A{1'b0}}};

    logic [A:0]   wptr_r;
    logic [A:0]   rptr_r;
    logic         inflight_r;
    logic [1:0]   buf_cnt_r;
    logic [D-1:0] head_r;
    logic [D-1:0] skid_r;
    logic [A:0]   count_r;
    logic         out_valid_r;

    logic         push_s;
    logic         pop_s;
    logic         read_s;
    logic [2:0]   occ_s;
    logic [1:0]   cnt_after_s;
    logic [1:0]   buf_cnt_n_s;
    logic [D-1:0] head_n_s;
    logic [D-1:0] skid_n_s;
    logic [A:0]   count_n_s;

    // Handshakes, RAM port drive and read-issue decision.
    always_comb begin
        in_ready  = !rst && (count_r < DEPTH_C);
        push_s    = in_valid && in_ready;
        pop_s     = out_valid_r && out_ready;
        // Buffer entries that will be taken once this pop and the in-flight word settle.
        occ_s     = {1'b0, buf_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        read_s    = (wptr_r != rptr_r) && (occ_s < 3'd2);
        ram_ena   = push_s;
        ram_wea   = push_s;
        ram_addra = wptr_r[A-1:0];
        ram_dia   = in_data;
        ram_enb   = read_s;
        ram_addrb = rptr_r[A-1:0];
    end

    // Next state of the head/skid buffer and the occupancy counter.
    always_comb begin
        head_n_s    = head_r;
        skid_n_s    = skid_r;
        cnt_after_s = buf_cnt_r - {1'b0, pop_s};
        if (pop_s) begin
            head_n_s = skid_r;
        end else begin
            head_n_s = head_r;
        end
        if (inflight_r) begin
            if (cnt_after_s == 2'd0) begin
                head_n_s = ram_dob;
            end else begin
                skid_n_s = ram_dob;
            end
            buf_cnt_n_s = cnt_after_s + 2'd1;
        end else begin
            buf_cnt_n_s = cnt_after_s;
        end
        case ({push_s, pop_s})
            2'b10:   count_n_s = count_r + {{A{1'b0}}, 1'b1};
            2'b01:   count_n_s = count_r - {{A{1'b0}}, 1'b1};
            default: count_n_s = count_r;
        endcase
    end

    // State registers; the asynchronous reset discards all contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r      <= {(A+1){1'b0}};
            rptr_r      <= {(A+1){1'b0}};
            inflight_r  <= 1'b0;
            buf_cnt_r   <= 2'd0;
            head_r      <= {D{1'b0}};
            skid_r      <= {D{1'b0}};
            count_r     <= {(A+1){1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + {{A{1'b0}}, 1'b1};
            end
            if (read_s) begin
                rptr_r <= rptr_r + {{A{1'b0}}, 1'b1};
            end
            inflight_r  <= read_s;
            buf_cnt_r   <= buf_cnt_n_s;
            head_r      <= head_n_s;
            skid_r      <= skid_n_s;
            count_r     <= count_n_s;
            out_valid_r <= (buf_cnt_n_s != 2'd0);
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = head_r;
    assign count     = count_r;

endmodule

// File: tb/tb_rams_sdp_fifo_ctrl.sv
// Self-checking bench: behavioural RAM, queue scoreboard of accepted words, count model.
module tb_rams_sdp_fifo_ctrl;

    localparam int D = 16;
    localparam int A = 10;
    localparam int DEPTH = 1 << A;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [D-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [D-1:0] out_data;
    logic [A:0]   count;
    logic         ram_ena;
    logic         ram_wea;
    logic [A-1:0] ram_addra;
    logic [D-1:0] ram_dia;
    logic         ram_enb;
    logic [A-1:0] ram_addrb;
    logic [D-1:0] ram_dob;

    logic [D-1:0] mem [0:DEPTH-1];

    int compared   = 0;
    int mismatched = 0;
    int cnt_m      = 0;
    int wcnt       = 0;
    int npop       = 0;
    logic [D-1:0] sb[$];

    rams_sdp_fifo_ctrl #(.D(D), .A(A)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
    );

    always #5 clk = ~clk;

    // Simple dual-port RAM with registered read port.
    always @(posedge clk) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= mem[ram_addrb];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, sample #1 later, predict what the next posedge does.
    task automatic step(input logic iv, input logic [D-1:0] d, input logic ordy);
        bit pu;
        bit po;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        chk("count", {21'd0, count}, cnt_m);
        chk("in_ready", {31'd0, in_ready}, {31'd0, (cnt_m < DEPTH)});
        if (cnt_m == 0) chk("empty_valid", {31'd0, out_valid}, 32'd0);
        pu = in_valid && in_ready;
        po = out_valid && out_ready;
        chk("wea", {31'd0, ram_wea}, {31'd0, pu});
        if (pu) begin
            chk("addra", {22'd0, ram_addra}, wcnt % DEPTH);
            wcnt++;
            sb.push_back(d);
        end
        if (po) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
            else chk("data", {16'd0, out_data}, {16'd0, sb.pop_front()});
            npop++;
        end
        cnt_m = cnt_m + int'(pu) - int'(po);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", {21'd0, count}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        sb.delete();
        cnt_m = 0;
        wcnt  = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 5000) begin
            step(1'b0, 16'h0, 1'b1);
            n++;
        end
        chk("drain_timeout", {31'd0, (n >= 5000)}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        do_reset();

        // 1: single word, 2-clock latency
        step(1'b1, 16'h0001, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        chk("t1_valid_e1", {31'd0, out_valid}, 32'd0);
        step(1'b0, 16'h0, 1'b0);
        chk("t1_valid_e2", {31'd0, out_valid}, 32'd0);
        step(1'b0, 16'h0, 1'b0);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_data", {16'd0, out_data}, 32'h1);
        drain();

        // 2: streaming with wrap
        npop = 0;
        for (int i = 0; i < 3000; i++) step(1'b1, D'(i), 1'b1);
        chk("t2_pops", npop, 32'd2997);
        drain();

        // 3: fill to full, refused push, push+pop at full
        for (int i = 0; i < DEPTH; i++) step(1'b1, D'(i + 16'h4000), 1'b0);
        step(1'b1, 16'hDEAD, 1'b0);
        chk("t3_full_count", {21'd0, count}, 32'd1024);
        chk("t3_full_ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, 16'hBEEF, 1'b1);
        step(1'b0, 16'h0, 1'b0);
        chk("t3_count_1023", {21'd0, count}, 32'd1023);
        drain();

        // 4: backpressure pattern 1,0,0,1 with random producer
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), D'($urandom), (i % 4 == 0) || (i % 4 == 3));
        drain();

        // 5: fill 5 and drain, then pop on empty
        for (int i = 0; i < 5; i++) step(1'b1, D'(16'h0500 + i), 1'b0);
        drain();
        step(1'b0, 16'h0, 1'b1);
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_enb", {31'd0, ram_enb}, 32'd0);
        step(1'b0, 16'h0, 1'b1);
        chk("t5_count", {21'd0, count}, 32'd0);

        // 6: reset with count=300 and a read in flight
        for (int i = 0; i < 300; i++) step(1'b1, D'(16'h6000 + i), 1'b0);
        step(1'b1, 16'h6FFF, 1'b1);
        do_reset();
        chk("t6_enb", {31'd0, ram_enb}, 32'd0);
        npop = 0;
        step(1'b1, 16'hABCD, 1'b0);
        for (int i = 0; i < 6 && npop == 0; i++) step(1'b0, 16'h0, 1'b1);
        chk("t6_first_pop", npop, 32'd1);
        chk("t6_sb_left", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
